seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: synchronized cycles an/seg must stay unchanged before a digit is captured.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: cycles without any capture before stall is flagged.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port an  input  4  anode selects, active-low; an[0] = seconds-units digit, an[3] = minutes-tens digit.
REQ-006 SHALL have port seg  input  7  segments, active-low, seg[0]=a ... seg[6]=g.
REQ-007 SHALL have port digits  output  16  captured BCD; digits[4k+3:4k] = digit k.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when digits updates.
REQ-009 SHALL have port frame_err  output  1  set with frame_valid when any digit in that frame was an illegal pattern.
REQ-010 SHALL have port bus_err  output  1  sticky; an had two or more bits low.
REQ-011 SHALL have port stalled  output  1  level; no capture for TIMEOUT_CYCLES.

Function
REQ-012 an and seg SHALL each pass a 2-flop synchronizer; all logic below uses synchronized values (2-cycle input latency).
REQ-013 Anode state SHALL be classified: BLANK (4'b1111), ONEHOT (exactly one bit low), ILLEGAL (two or more low).
REQ-014 FSM states SHALL be IDLE, SETTLE, HELD.
REQ-015 IDLE -> SETTLE when an is ONEHOT; settle counter loads 0.
REQ-016 In SETTLE, counter SHALL increment each cycle an and seg equal previous cycle; any change in seg SHALL reload 0; any change in an SHALL re-enter SETTLE (ONEHOT) or IDLE (BLANK/ILLEGAL).
REQ-017 When counter reaches SETTLE_CYCLES-1 SHALL capture the digit that cycle and go to HELD.
REQ-018 HELD SHALL ignore seg changes and exit only on an change: to SETTLE if ONEHOT, else IDLE; exactly one capture per anode assertion.
REQ-019 Decode: 7'h40->0, 7'h79->1, 7'h24->2, 7'h30->3, 7'h19->4, 7'h12->5, 7'h02->6, 7'h78->7, 7'h00->8, 7'h10->9; any other pattern SHALL store 4'hF and set that digit's shadow error bit.
REQ-020 Capture SHALL write shadow slot k and set seen[k]; recapture of same k before frame completion overwrites slot, seen unchanged.
REQ-021 On the capture that makes seen == 4'b1111, the next cycle SHALL copy shadow to digits, pulse frame_valid, drive frame_err = OR of shadow error bits, clear seen and error bits.
REQ-022 digits and frame_err SHALL hold between frames.
REQ-023 ILLEGAL an SHALL set bus_err (sticky until reset) and clear seen.
REQ-024 Timeout counter SHALL reset on every capture and saturate at TIMEOUT_CYCLES; on reaching it, stalled SHALL assert and seen SHALL clear.
REQ-025 stalled SHALL deassert the cycle after the next capture.
REQ-026 Capture and ILLEGAL in same cycle is impossible by REQ-013; capture coinciding with timeout SHALL take priority (timeout counter resets, stalled not set).
REQ-027 Scan order SHALL be irrelevant; any order covering all four anodes completes a frame.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, synchronizers 4'hF/7'h7F, counters 0, seen 0, shadow 0, digits 16'h0000, frame_valid 0, frame_err 0, bus_err 0, stalled 0.
REQ-029 Reset deassertion mid-scan SHALL begin from IDLE; first frame requires all four anodes captured anew.

Verification
REQ-030 Scan 1110/1101/1011/0111 with patterns for 9,5,2,1, each held 40 cycles -> one frame_valid, digits=16'h1259, frame_err=0.
REQ-031 Same scan with seg lagging an by 3 cycles per digit -> digits=16'h1259, no ghost capture of prior digit.
REQ-032 Digit 2 driven 7'h7F -> digits=16'h1F59, frame_err=1 with frame_valid.
REQ-033 Drive an=4'b1100 for 5 cycles mid-frame -> bus_err=1 persists, seen cleared, no frame_valid until four fresh captures.
REQ-034 Hold an=4'b1111 for TIMEOUT_CYCLES (set 100) -> stalled=1 at cycle 100; resume scan -> stalled=0 after first capture.
REQ-035 Assert rst_n low mid-digit-capture -> all outputs at reset values same cycle; next full scan yields correct digits.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Purpose: recover four BCD digits from a multiplexed active-low 7-segment scan (an/seg) and publish them as frames.
// Latency: 2-cycle synchronizer, SETTLE_CYCLES of stability per digit; digits/frame_valid appear the cycle after the completing capture.
// Backpressure: none; the scan is free-running, so each frame is a one-cycle pulse and digits hold until the next frame.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        bus_err,
    output logic        stalled
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HELD} state_t;

    logic [3:0]    an_s1_q, an_s2_q, an_p_q;
    logic [6:0]    seg_s1_q, seg_s2_q, seg_p_q;
    state_t        state_q;
    logic [SW-1:0] cnt_q;
    logic [TW-1:0] tmo_q;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    serr_q, serr_d;
    logic [15:0]   digits_q, digits_d;
    logic          frame_valid_q, frame_err_q, frame_err_d, bus_err_q, stalled_q;

    logic [3:0]    an_low;
    logic          an_onehot, an_illegal, an_chg, seg_chg;
    logic [1:0]    cap_slot;
    logic          cap_now, tmo_hit, frame_done;
    logic [3:0]    dec_val;
    logic          dec_bad;

    // Two-flop synchronizers plus one extra stage so "unchanged since last cycle" is a register compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1_q  <= 4'hF;
            an_s2_q  <= 4'hF;
            an_p_q   <= 4'hF;
            seg_s1_q <= 7'h7F;
            seg_s2_q <= 7'h7F;
            seg_p_q  <= 7'h7F;
        end else begin
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
            an_p_q   <= an_s2_q;
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            seg_p_q  <= seg_s2_q;
        end
    end

    // Classify the anode word, detect changes, and decide whether this cycle captures a digit.
    always_comb begin
        an_low     = ~an_s2_q;
        an_onehot  = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
        an_illegal = (an_low != 4'd0) && !an_onehot;
        an_chg     = (an_s2_q != an_p_q);
        seg_chg    = (seg_s2_q != seg_p_q);
        cap_slot   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (an_low[i]) cap_slot = 2'(i);
        end
        cap_now = (state_q == ST_SETTLE) && !an_chg && !seg_chg && (cnt_q == SET_LAST);
        // A capture in the same cycle as the timeout wins: the timeout is simply not taken.
        tmo_hit = !cap_now && (tmo_q == TMO_MAX - TW'(1));
    end

    // Segment pattern to BCD; anything unrecognised becomes F and is flagged.
    always_comb begin
        dec_bad = 1'b0;
        case (seg_s2_q)
            7'h40:   dec_val = 4'd0;
            7'h79:   dec_val = 4'd1;
            7'h24:   dec_val = 4'd2;
            7'h30:   dec_val = 4'd3;
            7'h19:   dec_val = 4'd4;
            7'h12:   dec_val = 4'd5;
            7'h02:   dec_val = 4'd6;
            7'h78:   dec_val = 4'd7;
            7'h00:   dec_val = 4'd8;
            7'h10:   dec_val = 4'd9;
            default: begin
                dec_val = 4'hF;
                dec_bad = 1'b1;
            end
        endcase
    end

    // Shadow/seen bookkeeping; a frame is published on the capture that fills the last missing slot.
    always_comb begin
        shadow_d    = shadow_q;
        serr_d      = serr_q;
        seen_d      = seen_q;
        digits_d    = digits_q;
        frame_err_d = frame_err_q;
        frame_done  = 1'b0;
        if (cap_now) begin
            shadow_d[{cap_slot, 2'b00} +: 4] = dec_val;
            serr_d[cap_slot]                 = dec_bad;
            seen_d[cap_slot]                 = 1'b1;
        end
        if (cap_now && (seen_d == 4'hF)) begin
            frame_done  = 1'b1;
            digits_d    = shadow_d;
            frame_err_d = |serr_d;
            seen_d      = 4'd0;
            serr_d      = 4'd0;
        end else if (an_illegal || tmo_hit) begin
            seen_d = 4'd0;
        end
    end

    // Scan FSM with its settle counter: exactly one capture per anode assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (an_onehot) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (an_chg) begin
                        state_q <= an_onehot ? ST_SETTLE : ST_IDLE;
                        cnt_q   <= '0;
                    end else if (seg_chg) begin
                        cnt_q <= '0;
                    end else if (cnt_q == SET_LAST) begin
                        state_q <= ST_HELD;
                    end else begin
                        cnt_q <= cnt_q + SW'(1);
                    end
                end
                ST_HELD: begin
                    if (an_chg) begin
                        state_q <= an_onehot ? ST_SETTLE : ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Frame registers, sticky bus error, and the capture-starvation watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= 16'h0000;
            serr_q        <= 4'd0;
            seen_q        <= 4'd0;
            digits_q      <= 16'h0000;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            bus_err_q     <= 1'b0;
            tmo_q         <= '0;
            stalled_q     <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            serr_q        <= serr_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_done;
            frame_err_q   <= frame_err_d;
            bus_err_q     <= bus_err_q | an_illegal;
            if (cap_now) begin
                tmo_q     <= '0;
                stalled_q <= 1'b0;
            end else begin
                if (tmo_q != TMO_MAX) tmo_q <= tmo_q + TW'(1);
                if (tmo_hit) stalled_q <= 1'b1;
            end
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign bus_err     = bus_err_q;
    assign stalled     = stalled_q;

endmodule
